calc2_issue_arb: RTL and testbench



---
 rtl/calc2_arb_pkg.sv | 37 +++
 rtl/calc2_rr_pick.sv | 29 ++
 rtl/calc2_issue_arb.sv | 230 +++++++++++++++++++++++
 tb/tb_calc2_issue_arb.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc2_arb_pkg.sv
// calc2 issue arbiter: shared command encodings, sizes and decode helpers.
package calc2_arb_pkg;

    localparam int NPORT = 4;
    localparam int TAGW  = 2;

    localparam logic [3:0] CMD_IDLE = 4'd0;
    localparam logic [3:0] CMD_ADD  = 4'd1;
    localparam logic [3:0] CMD_SUB  = 4'd2;
    localparam logic [3:0] CMD_SHL  = 4'd5;
    localparam logic [3:0] CMD_SHR  = 4'd6;

    // Which execution path a command is routed to.
    typedef enum logic [1:0] {
        UNIT_NONE = 2'd0,
        UNIT_ADD  = 2'd1,
        UNIT_SHF  = 2'd2,
        UNIT_INV  = 2'd3
    } unit_e;

    function automatic unit_e decode_unit(input logic [3:0] cmd);
        unit_e u;
        case (cmd)
            CMD_IDLE:         u = UNIT_NONE;
            CMD_ADD, CMD_SUB: u = UNIT_ADD;
            CMD_SHL, CMD_SHR: u = UNIT_SHF;
            default:          u = UNIT_INV;
        endcase
        return u;
    endfunction

    // Flat index of a (port, tag) pair in the 16-entry outstanding table.
    function automatic logic [3:0] pair_idx(input logic [1:0] port, input logic [TAGW-1:0] tag);
        return {port, tag};
    endfunction

endpackage

// File: rtl/calc2_rr_pick.sv
// calc2 issue arbiter: rotating first-eligible picker.
// Returns a one-hot grant for the first set bit of elig found when scanning
// upward (with wrap) from ptr. A ptr of 0 gives plain fixed priority 0>1>2>3.
module calc2_rr_pick
    import calc2_arb_pkg::*;
(
    input  logic [NPORT-1:0] elig,
    input  logic [1:0]       ptr,
    output logic [NPORT-1:0] gnt
);

    logic       found;
    logic [1:0] idx;

    // Scan the four slots starting at ptr; the first eligible slot wins.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = ptr;
        for (int i = 0; i < NPORT; i++) begin
            idx = ptr + 2'(i);
            if (!found && elig[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/calc2_issue_arb.sv
// calc2 issue scheduler: arbitrates four requester ports onto the shared
// adder and shifter pipelines, tracks outstanding (port,tag) pairs, and
// diverts illegal commands to the per-port invalid pulse.
// Build option: define CALC2_ARB_RR_EN for per-unit round-robin arbitration;
// otherwise both units use fixed priority port 0 > 1 > 2 > 3.
//
// Issue handshake: a unit's issue register is free when !vld | rdy. A grant
// loads the register (vld=1 on the next cycle). While vld & !rdy every issue
// field holds stable. vld falls after rdy unless a new grant loads that cycle.
module calc2_issue_arb
    import calc2_arb_pkg::*;
(
    input  logic        c_clk,
    input  logic        reset,
    input  logic [0:15] req_cmd,
    input  logic [0:7]  req_tag,
    output logic [0:3]  req_ack,
    output logic        add_vld,
    input  logic        add_rdy,
    output logic [0:3]  add_cmd,
    output logic [0:1]  add_port,
    output logic [0:1]  add_tag,
    output logic        shf_vld,
    input  logic        shf_rdy,
    output logic [0:3]  shf_cmd,
    output logic [0:1]  shf_port,
    output logic [0:1]  shf_tag,
    input  logic        add_done,
    input  logic [0:1]  add_done_port,
    input  logic [0:1]  add_done_tag,
    input  logic        shf_done,
    input  logic [0:1]  shf_done_port,
    input  logic [0:1]  shf_done_tag,
    output logic [0:3]  inv_vld,
    output logic [0:7]  inv_tag,
    output logic        tag_err
);

    logic [3:0]       cmd_p  [NPORT];
    logic [TAGW-1:0]  tag_p  [NPORT];
    unit_e            unit_p [NPORT];
    logic [NPORT-1:0] add_elig, shf_elig, inv_hit;
    logic [NPORT-1:0] add_gnt, shf_gnt;
    logic             add_free, shf_free;
    logic [1:0]       add_ptr, shf_ptr;

    logic [15:0]      outst_q, outst_d;
    logic             add_vld_q, add_vld_d, shf_vld_q, shf_vld_d;
    logic [3:0]       add_cmd_q, add_cmd_d, shf_cmd_q, shf_cmd_d;
    logic [1:0]       add_port_q, add_port_d, shf_port_q, shf_port_d;
    logic [1:0]       add_tag_q, add_tag_d, shf_tag_q, shf_tag_d;
    logic [0:3]       inv_vld_q, inv_vld_d;
    logic [0:7]       inv_tag_q, inv_tag_d;
    logic             tag_err_q, tag_err_d;

    // Decode each port and decide which requests may compete this cycle.
    // The table is read as registered, so a done arriving this cycle only
    // makes its pair eligible from the next cycle on.
    always_comb begin
        add_free = !add_vld_q || add_rdy;
        shf_free = !shf_vld_q || shf_rdy;
        add_elig = '0;
        shf_elig = '0;
        inv_hit  = '0;
        for (int p = 0; p < NPORT; p++) begin
            cmd_p[p]  = req_cmd[4*p +: 4];
            tag_p[p]  = req_tag[2*p +: 2];
            unit_p[p] = decode_unit(cmd_p[p]);
            add_elig[p] = !reset && add_free && (unit_p[p] == UNIT_ADD)
                          && !outst_q[pair_idx(2'(p), tag_p[p])];
            shf_elig[p] = !reset && shf_free && (unit_p[p] == UNIT_SHF)
                          && !outst_q[pair_idx(2'(p), tag_p[p])];
            inv_hit[p]  = !reset && (unit_p[p] == UNIT_INV);
        end
    end

    calc2_rr_pick u_add_pick (
        .elig (add_elig),
        .ptr  (add_ptr),
        .gnt  (add_gnt)
    );

    calc2_rr_pick u_shf_pick (
        .elig (shf_elig),
        .ptr  (shf_ptr),
        .gnt  (shf_gnt)
    );

`ifdef CALC2_ARB_RR_EN
    logic [1:0] add_ptr_q, add_ptr_d, shf_ptr_q, shf_ptr_d;

    // Advance each unit's pointer past the port it just granted.
    always_comb begin
        add_ptr_d = add_ptr_q;
        shf_ptr_d = shf_ptr_q;
        for (int p = 0; p < NPORT; p++) begin
            if (add_gnt[p]) add_ptr_d = 2'(p) + 2'd1;
            if (shf_gnt[p]) shf_ptr_d = 2'(p) + 2'd1;
        end
    end

    // Round-robin pointer registers.
    always_ff @(posedge c_clk) begin
        if (reset) begin
            add_ptr_q <= '0;
            shf_ptr_q <= '0;
        end else begin
            add_ptr_q <= add_ptr_d;
            shf_ptr_q <= shf_ptr_d;
        end
    end

    assign add_ptr = add_ptr_q;
    assign shf_ptr = shf_ptr_q;
`else
    assign add_ptr = 2'd0;
    assign shf_ptr = 2'd0;
`endif

    // Acknowledge granted requests and every invalid command immediately.
    always_comb begin
        req_ack = '0;
        for (int p = 0; p < NPORT; p++) begin
            req_ack[p] = add_gnt[p] | shf_gnt[p] | inv_hit[p];
        end
    end

    // Issue registers: load on grant, drop vld once the unit has accepted.
    always_comb begin
        add_vld_d  = add_vld_q;
        add_cmd_d  = add_cmd_q;
        add_port_d = add_port_q;
        add_tag_d  = add_tag_q;
        shf_vld_d  = shf_vld_q;
        shf_cmd_d  = shf_cmd_q;
        shf_port_d = shf_port_q;
        shf_tag_d  = shf_tag_q;
        if (|add_gnt) begin
            add_vld_d = 1'b1;
            for (int p = 0; p < NPORT; p++) begin
                if (add_gnt[p]) begin
                    add_cmd_d  = cmd_p[p];
                    add_port_d = 2'(p);
                    add_tag_d  = tag_p[p];
                end
            end
        end else if (add_rdy) begin
            add_vld_d = 1'b0;
        end
        if (|shf_gnt) begin
            shf_vld_d = 1'b1;
            for (int p = 0; p < NPORT; p++) begin
                if (shf_gnt[p]) begin
                    shf_cmd_d  = cmd_p[p];
                    shf_port_d = 2'(p);
                    shf_tag_d  = tag_p[p];
                end
            end
        end else if (shf_rdy) begin
            shf_vld_d = 1'b0;
        end
    end

    // Outstanding table: completions clear, grants set. A done for a pair
    // that is not outstanding raises tag_err on the following cycle.
    always_comb begin
        outst_d   = outst_q;
        tag_err_d = (add_done && !outst_q[pair_idx(add_done_port, add_done_tag)])
                 || (shf_done && !outst_q[pair_idx(shf_done_port, shf_done_tag)]);
        if (add_done) outst_d[pair_idx(add_done_port, add_done_tag)] = 1'b0;
        if (shf_done) outst_d[pair_idx(shf_done_port, shf_done_tag)] = 1'b0;
        for (int p = 0; p < NPORT; p++) begin
            if (add_gnt[p] || shf_gnt[p]) outst_d[pair_idx(2'(p), tag_p[p])] = 1'b1;
        end
    end

    // Invalid-op pulse and its tag, one cycle after the command was seen.
    always_comb begin
        inv_vld_d = '0;
        inv_tag_d = '0;
        for (int p = 0; p < NPORT; p++) begin
            inv_vld_d[p] = inv_hit[p];
            if (inv_hit[p]) inv_tag_d[2*p +: 2] = tag_p[p];
        end
    end

    // State registers; reset drops any in-flight issue and clears the table.
    always_ff @(posedge c_clk) begin
        if (reset) begin
            outst_q    <= '0;
            add_vld_q  <= 1'b0;
            add_cmd_q  <= '0;
            add_port_q <= '0;
            add_tag_q  <= '0;
            shf_vld_q  <= 1'b0;
            shf_cmd_q  <= '0;
            shf_port_q <= '0;
            shf_tag_q  <= '0;
            inv_vld_q  <= '0;
            inv_tag_q  <= '0;
            tag_err_q  <= 1'b0;
        end else begin
            outst_q    <= outst_d;
            add_vld_q  <= add_vld_d;
            add_cmd_q  <= add_cmd_d;
            add_port_q <= add_port_d;
            add_tag_q  <= add_tag_d;
            shf_vld_q  <= shf_vld_d;
            shf_cmd_q  <= shf_cmd_d;
            shf_port_q <= shf_port_d;
            shf_tag_q  <= shf_tag_d;
            inv_vld_q  <= inv_vld_d;
            inv_tag_q  <= inv_tag_d;
            tag_err_q  <= tag_err_d;
        end
    end

    assign add_vld  = add_vld_q;
    assign add_cmd  = add_cmd_q;
    assign add_port = add_port_q;
    assign add_tag  = add_tag_q;
    assign shf_vld  = shf_vld_q;
    assign shf_cmd  = shf_cmd_q;
    assign shf_port = shf_port_q;
    assign shf_tag  = shf_tag_q;
    assign inv_vld  = inv_vld_q;
    assign inv_tag  = inv_tag_q;
    assign tag_err  = tag_err_q;

endmodule

// File: tb/tb_calc2_issue_arb.sv
// Self-checking bench for calc2_issue_arb: directed scenarios followed by
// randomized traffic, all checked against a cycle-level reference model.
module tb_calc2_issue_arb;

    // ---------------- clock / reset / DUT ----------------
    logic        c_clk = 1'b0;
    logic        reset;
    logic [0:15] req_cmd;
    logic [0:7]  req_tag;
    logic [0:3]  req_ack;
    logic        add_vld, add_rdy, shf_vld, shf_rdy;
    logic [0:3]  add_cmd, shf_cmd;
    logic [0:1]  add_port, add_tag, shf_port, shf_tag;
    logic        add_done, shf_done;
    logic [0:1]  add_done_port, add_done_tag, shf_done_port, shf_done_tag;
    logic [0:3]  inv_vld;
    logic [0:7]  inv_tag;
    logic        tag_err;

    always #5 c_clk = ~c_clk;

    calc2_issue_arb dut (
        .c_clk(c_clk), .reset(reset),
        .req_cmd(req_cmd), .req_tag(req_tag), .req_ack(req_ack),
        .add_vld(add_vld), .add_rdy(add_rdy), .add_cmd(add_cmd),
        .add_port(add_port), .add_tag(add_tag),
        .shf_vld(shf_vld), .shf_rdy(shf_rdy), .shf_cmd(shf_cmd),
        .shf_port(shf_port), .shf_tag(shf_tag),
        .add_done(add_done), .add_done_port(add_done_port), .add_done_tag(add_done_tag),
        .shf_done(shf_done), .shf_done_port(shf_done_port), .shf_done_tag(shf_done_tag),
        .inv_vld(inv_vld), .inv_tag(inv_tag), .tag_err(tag_err)
    );

    // ---------------- bench state ----------------
    logic [3:0] d_cmd [4];
    logic [1:0] d_tag [4];
    logic [3:0] obs_ack;          // bit p = port p acked in the last cycle
    int         n_cmp = 0;
    int         n_err = 0;

    // reference model
    bit         m_out [4][4];
    logic       m_add_vld, m_shf_vld, m_tag_err;
    logic [3:0] m_add_cmd, m_shf_cmd;
    logic [1:0] m_add_port, m_add_tag, m_shf_port, m_shf_tag;
    int         m_add_ptr, m_shf_ptr;
    logic [3:0] m_inv_vld;
    logic [1:0] m_inv_tag [4];

    // scoreboards: granted ops awaiting acceptance, and accepted pairs awaiting done
    logic [7:0] add_exp_q[$];
    logic [7:0] shf_exp_q[$];
    logic [3:0] add_fl[$];
    logic [3:0] shf_fl[$];

    function automatic bit is_add(input logic [3:0] c);
        return (c == 4'd1) || (c == 4'd2);
    endfunction
    function automatic bit is_shf(input logic [3:0] c);
        return (c == 4'd5) || (c == 4'd6);
    endfunction
    function automatic bit is_inv(input logic [3:0] c);
        return (c != 4'd0) && !is_add(c) && !is_shf(c);
    endfunction

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    task automatic model_clear();
        foreach (m_out[i, j]) m_out[i][j] = 1'b0;
        m_add_vld = 0; m_shf_vld = 0; m_tag_err = 0;
        m_add_cmd = 0; m_shf_cmd = 0; m_add_port = 0; m_add_tag = 0;
        m_shf_port = 0; m_shf_tag = 0; m_add_ptr = 0; m_shf_ptr = 0;
        m_inv_vld = 0;
        for (int i = 0; i < 4; i++) m_inv_tag[i] = 0;
        add_exp_q.delete();
        shf_exp_q.delete();
    endtask

    // One clock cycle: drive inputs, check the combinational ack, step the
    // model, then check registered outputs just after the edge.
    task automatic cycle();
        int ag, sg, p;
        bit afree, sfree;
        logic [0:3] exp_ack;
        for (int i = 0; i < 4; i++) begin
            req_cmd[4*i +: 4] = d_cmd[i];
            req_tag[2*i +: 2] = d_tag[i];
        end
        #2;
        ag = -1; sg = -1; exp_ack = '0;
        if (!reset) begin
            afree = !m_add_vld || add_rdy;
            sfree = !m_shf_vld || shf_rdy;
            for (int i = 0; i < 4; i++) begin
                p = (m_add_ptr + i) % 4;
                if (ag < 0 && afree && is_add(d_cmd[p]) && !m_out[p][d_tag[p]]) ag = p;
                p = (m_shf_ptr + i) % 4;
                if (sg < 0 && sfree && is_shf(d_cmd[p]) && !m_out[p][d_tag[p]]) sg = p;
            end
            for (int i = 0; i < 4; i++) if (is_inv(d_cmd[i])) exp_ack[i] = 1'b1;
            if (ag >= 0) exp_ack[ag] = 1'b1;
            if (sg >= 0) exp_ack[sg] = 1'b1;
        end
        check("req_ack", req_ack, exp_ack);
        for (int i = 0; i < 4; i++) obs_ack[i] = req_ack[i];

        if (!reset && add_vld && add_rdy) begin
            check("add_sb_nonempty", 32'(add_exp_q.size() != 0), 1);
            if (add_exp_q.size() != 0) check("add_sb", {add_cmd, add_port, add_tag}, add_exp_q.pop_front());
            add_fl.push_back({add_port, add_tag});
        end
        if (!reset && shf_vld && shf_rdy) begin
            check("shf_sb_nonempty", 32'(shf_exp_q.size() != 0), 1);
            if (shf_exp_q.size() != 0) check("shf_sb", {shf_cmd, shf_port, shf_tag}, shf_exp_q.pop_front());
            shf_fl.push_back({shf_port, shf_tag});
        end

        if (reset) begin
            model_clear();
        end else begin
            m_tag_err = (add_done && !m_out[add_done_port][add_done_tag])
                     || (shf_done && !m_out[shf_done_port][shf_done_tag]);
            if (add_done) m_out[add_done_port][add_done_tag] = 1'b0;
            if (shf_done) m_out[shf_done_port][shf_done_tag] = 1'b0;
            if (ag >= 0) begin
                m_out[ag][d_tag[ag]] = 1'b1;
                m_add_vld = 1; m_add_cmd = d_cmd[ag]; m_add_port = 2'(ag); m_add_tag = d_tag[ag];
                add_exp_q.push_back({m_add_cmd, m_add_port, m_add_tag});
`ifdef CALC2_ARB_RR_EN
                m_add_ptr = (ag + 1) % 4;
`endif
            end else if (add_rdy) begin
                m_add_vld = 0;
            end
            if (sg >= 0) begin
                m_out[sg][d_tag[sg]] = 1'b1;
                m_shf_vld = 1; m_shf_cmd = d_cmd[sg]; m_shf_port = 2'(sg); m_shf_tag = d_tag[sg];
                shf_exp_q.push_back({m_shf_cmd, m_shf_port, m_shf_tag});
`ifdef CALC2_ARB_RR_EN
                m_shf_ptr = (sg + 1) % 4;
`endif
            end else if (shf_rdy) begin
                m_shf_vld = 0;
            end
            for (int i = 0; i < 4; i++) begin
                m_inv_vld[i] = is_inv(d_cmd[i]);
                m_inv_tag[i] = d_tag[i];
            end
        end

        @(posedge c_clk);
        #1;
        check("add_vld", add_vld, m_add_vld);
        if (m_add_vld) begin
            check("add_cmd", add_cmd, m_add_cmd);
            check("add_port", add_port, m_add_port);
            check("add_tag", add_tag, m_add_tag);
        end
        check("shf_vld", shf_vld, m_shf_vld);
        if (m_shf_vld) begin
            check("shf_cmd", shf_cmd, m_shf_cmd);
            check("shf_port", shf_port, m_shf_port);
            check("shf_tag", shf_tag, m_shf_tag);
        end
        check("tag_err", tag_err, m_tag_err);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("inv_vld%0d", i), inv_vld[i], m_inv_vld[i]);
            if (m_inv_vld[i]) check($sformatf("inv_tag%0d", i), inv_tag[2*i +: 2], m_inv_tag[i]);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        for (int i = 0; i < 4; i++) begin d_cmd[i] = 0; d_tag[i] = 0; end
        add_done = 0; add_done_port = 0; add_done_tag = 0;
        shf_done = 0; shf_done_port = 0; shf_done_tag = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        cycle();
        cycle();
        reset = 0;
    endtask

    logic [3:0] cmd_tbl [8];
    logic [3:0] pr;
    int         idx;
    int         nt0;
    int         exp_g;

    // ---------------- directed + random sequence ----------------
    initial begin
        cmd_tbl = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd6, 4'd0, 4'd9, 4'd15};
        add_rdy = 1; shf_rdy = 1;
        obs_ack = 0;
        model_clear();
        idle_inputs();
        req_cmd = 0; req_tag = 0;
        reset = 1;
        @(posedge c_clk); #1;

        // reset state
        do_reset();
        check("rst_add_vld", add_vld, 0);
        check("rst_shf_vld", shf_vld, 0);
        check("rst_inv_vld", inv_vld, 0);
        check("rst_tag_err", tag_err, 0);

        // first issue: ack in cycle 0, add_vld with port0 tag0 in cycle 1
        d_cmd[0] = 1; d_tag[0] = 0;
        cycle();
        check("first_ack", obs_ack, 4'b0001);
        check("first_vld", add_vld, 1);
        check("first_port", add_port, 0);
        check("first_tag", add_tag, 0);
        d_cmd[0] = 0;
        add_done = 1; add_done_port = 0; add_done_tag = 0;
        cycle();
        add_done = 0;

        // tag block: port1 tag2 held off until its done has been seen
        d_cmd[1] = 1; d_tag[1] = 2;
        cycle();
        check("blk_first_ack", obs_ack[1], 1);
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("blk_held", obs_ack[1], 0);
        end
        add_done = 1; add_done_port = 1; add_done_tag = 2;
        cycle();
        check("blk_done_same_cycle", obs_ack[1], 0);
        add_done = 0;
        cycle();
        check("blk_after_done", obs_ack[1], 1);
        check("blk_reissue_port", add_port, 1);
        check("blk_reissue_tag", add_tag, 2);
        d_cmd[1] = 0;
        cycle();

        // contention: all four ports want the adder
        do_reset();
        for (int i = 0; i < 4; i++) begin d_cmd[i] = 1; d_tag[i] = 0; end
        nt0 = 1;
        for (int k = 0; k < 4; k++) begin
            cycle();
`ifdef CALC2_ARB_RR_EN
            exp_g = k;
`else
            exp_g = 0;
`endif
            check($sformatf("cont_grant%0d", k), obs_ack, 32'(1) << exp_g);
            for (int i = 0; i < 4; i++) begin
                if (obs_ack[i]) begin
                    if (i == 0) begin d_tag[0] = 2'(nt0); nt0++; end
                    else d_cmd[i] = 0;
                end
            end
        end
        idle_inputs();
        cycle();

        // parallel issue to both units
        do_reset();
        d_cmd[2] = 5; d_tag[2] = 1;
        d_cmd[3] = 2; d_tag[3] = 3;
        cycle();
        check("par_ack", obs_ack, 4'b1100);
        check("par_shf_vld", shf_vld, 1);
        check("par_shf_port", shf_port, 2);
        check("par_add_vld", add_vld, 1);
        check("par_add_port", add_port, 3);
        d_cmd[2] = 0; d_cmd[3] = 0;

        // back-pressure on the adder; shifter keeps issuing
        add_rdy = 0;
        d_cmd[0] = 1; d_tag[0] = 0;
        d_cmd[1] = 5; d_tag[1] = 0;
        cycle();
        check("bp_shf_ack", obs_ack[1], 1);
        check("bp_shf_port", shf_port, 1);
        d_cmd[1] = 0;
        for (int k = 0; k < 4; k++) begin
            cycle();
            check("bp_no_add_ack", obs_ack[0], 0);
            check("bp_add_vld", add_vld, 1);
            check("bp_add_port", add_port, 3);
            check("bp_add_tag", add_tag, 3);
        end
        add_rdy = 1;
        cycle();
        check("bp_release_ack", obs_ack[0], 1);
        check("bp_release_port", add_port, 0);
        d_cmd[0] = 0;

        // invalid command, then a spurious done
        d_cmd[3] = 15; d_tag[3] = 1;
        cycle();
        check("inv_ack", obs_ack[3], 1);
        check("inv_pulse", inv_vld[3], 1);
        check("inv_tag3", inv_tag[6 +: 2], 1);
        d_cmd[3] = 0;
        shf_done = 1; shf_done_port = 0; shf_done_tag = 3;
        cycle();
        shf_done = 0;
        check("spurious_tag_err", tag_err, 1);
        check("inv_pulse_gone", inv_vld[3], 0);

        // reset while an issue is in flight, then a late done
        d_cmd[2] = 1; d_tag[2] = 2;
        cycle();
        d_cmd[2] = 0; add_rdy = 0;
        reset = 1;
        cycle();
        reset = 0; add_rdy = 1;
        check("midrst_add_vld", add_vld, 0);
        add_done = 1; add_done_port = 2; add_done_tag = 2;
        cycle();
        add_done = 0;
        check("late_done_tag_err", tag_err, 1);

        // randomized traffic
        do_reset();
        add_fl.delete();
        shf_fl.delete();
        for (int n = 0; n < 1500; n++) begin
            add_rdy = ($urandom_range(0, 3) != 0);
            shf_rdy = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 4; i++) begin
                if (obs_ack[i] || $urandom_range(0, 7) == 0) begin
                    d_cmd[i] = cmd_tbl[$urandom_range(0, 7)];
                    d_tag[i] = 2'($urandom_range(0, 3));
                end
            end
            add_done = 0; shf_done = 0;
            if (add_fl.size() != 0 && $urandom_range(0, 2) == 0) begin
                idx = $urandom_range(0, add_fl.size() - 1);
                pr = add_fl[idx];
                add_fl.delete(idx);
                add_done = 1; add_done_port = pr[3:2]; add_done_tag = pr[1:0];
            end else if ($urandom_range(0, 40) == 0) begin
                add_done = 1; add_done_port = 2'($urandom_range(0, 3)); add_done_tag = 2'($urandom_range(0, 3));
            end
            if (shf_fl.size() != 0 && $urandom_range(0, 2) == 0) begin
                idx = $urandom_range(0, shf_fl.size() - 1);
                pr = shf_fl[idx];
                shf_fl.delete(idx);
                shf_done = 1; shf_done_port = pr[3:2]; shf_done_tag = pr[1:0];
            end else if ($urandom_range(0, 40) == 0) begin
                shf_done = 1; shf_done_port = 2'($urandom_range(0, 3)); shf_done_tag = 2'($urandom_range(0, 3));
            end
            reset = ($urandom_range(0, 300) == 0);
            cycle();
            reset = 0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
